muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand width in bits (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  meaning reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  meaning request strobe, sampled only in IDLE.
REQ-005 SHALL have port op  input  2  meaning operation: MUL=0, DIV=1, MADD=2, MSUB=3.
REQ-006 SHALL have port sign  input  1  meaning 1 = signed operands, 0 = unsigned.
REQ-007 SHALL have ports srca and srcb  input  WIDTH  meaning the operands (dividend/divisor for DIV).
REQ-008 SHALL have ports acc_hi and acc_lo  input  WIDTH  meaning the accumulator for MADD/MSUB.
REQ-009 SHALL have port flush  input  1  meaning abort request from exception or pipeline flush.
REQ-010 SHALL have port busy  output  1  meaning an operation is in flight.
REQ-011 SHALL have port out_valid  output  1  meaning a one-cycle result pulse.
REQ-012 SHALL have ports hi and lo  output  WIDTH  meaning the result registers.
REQ-013 SHALL have port div_zero  output  1  meaning a divide by zero, qualified by out_valid.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, ACC, DONE; in_valid in IDLE moves to CALC and samples all operands, op and sign.
REQ-015 SHALL compute MUL as a radix-2 shift-add over WIDTH CALC cycles on operand magnitudes, sign-fixing the 2*WIDTH product at the end; hi = upper half, lo = lower half.
REQ-016 SHALL compute DIV as a restoring divide over WIDTH CALC cycles; lo = quotient, hi = remainder; signed remainder takes the dividend's sign.
REQ-017 SHALL, for DIV with srcb=0, give lo = all ones and hi = srca, and assert div_zero with out_valid.
REQ-018 SHALL, for signed DIV of minimum-negative by -1, give lo = minimum-negative and hi = 0.
REQ-019 SHALL pulse out_valid for exactly one cycle (DONE) WIDTH+1 cycles after acceptance for MUL/DIV, and WIDTH+2 cycles after acceptance for MADD/MSUB (via ACC), then return to IDLE.
REQ-020 SHALL hold hi, lo and div_zero stable from out_valid until the next out_valid.
REQ-021 SHALL assert busy in CALC, ACC and DONE, and SHALL ignore in_valid while busy.
REQ-022 SHALL, on flush in any state, enter IDLE on the next edge with no out_valid, leaving hi/lo unchanged.
REQ-023 SHALL let flush win over a coincident in_valid or a coincident completion.

Reset
REQ-024 SHALL, with rst low, force state=IDLE and busy=0, out_valid=0, div_zero=0, hi=0 and lo=0 immediately, including mid-operation.
REQ-025 SHALL accept in_valid on the first rising edge after rst deasserts.

Configuration
REQ-026 SHALL, with macro MULDIV_MACC_EN defined, make MADD/MSUB produce {acc_hi,acc_lo} plus/minus the product, modulo 2^(2*WIDTH), using state ACC.
REQ-027 SHALL, without MULDIV_MACC_EN, remove the ACC state and accumulator logic, decode MADD/MSUB as MUL with WIDTH+1 latency, and leave acc_hi/acc_lo unused.

Structure
REQ-028 SHALL take the op encoding enum, FSM state enum and default WIDTH constant from shared package muldiv_pkg.
REQ-029 SHALL place one shift/subtract iteration (shared by MUL and DIV) in sub-module muldiv_step.

Verification (WIDTH=32; "cycle N" means N edges after acceptance)
REQ-030 SHALL cover: signed MUL -3*5 -> out_valid at cycle 33, hi=FFFFFFFF, lo=FFFFFFF1.
REQ-031 SHALL cover: unsigned DIV 100/7 -> lo=0000000E, hi=00000002; signed DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
REQ-032 SHALL cover: DIV 00001234/0 -> lo=FFFFFFFF, hi=00001234, div_zero=1 with out_valid; then signed 80000000/FFFFFFFF -> lo=80000000, hi=0.
REQ-033 SHALL cover: flush at cycle 10 of a MUL -> no out_valid, busy=0 the next cycle, a new MUL accepted immediately completes correctly.
REQ-034 SHALL cover: MADD acc=00000000_FFFFFFFF, 1*1 -> hi=00000001, lo=00000000 at cycle 34 with the macro; hi=0, lo=1 at cycle 33 without it.
REQ-035 SHALL cover: rst low at cycle 5 of a DIV -> all outputs 0 immediately, no out_valid after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Optional multiply-accumulate support is enabled by defining MULDIV_MACC_EN.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_DIV  = 2'd1,
    OP_MADD = 2'd2,
    OP_MSUB = 2'd3
  } op_t;

`ifdef MULDIV_MACC_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  function automatic logic is_macc_op(input op_t o);
    return (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, shift-subtract (restoring) for divide.
// A single WIDTH+1 bit adder serves both modes.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             div,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_next,
  output logic [WIDTH-1:0] lo_next
);

  logic [WIDTH:0]   base;
  logic [WIDTH:0]   addend;
  logic             cin;
  logic [WIDTH+1:0] sum;

  always_comb begin
    if (div) begin
      base   = {hi, lo[WIDTH-1]};
      addend = ~{1'b0, b};
      cin    = 1'b1;
    end else begin
      base   = {1'b0, hi};
      addend = {1'b0, b};
      cin    = 1'b0;
    end
    sum = {1'b0, base} + {1'b0, addend} + (WIDTH+2)'(cin);

    // Divide: carry out means the trial subtraction did not borrow.
    if (div) begin
      if (sum[WIDTH+1]) begin
        hi_next = sum[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b1};
      end else begin
        hi_next = base[WIDTH-1:0];
        lo_next = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      hi_next = sum[WIDTH:1];
      lo_next = {sum[0], lo[WIDTH-1:1]};
    end else begin
      hi_next = base[WIDTH:1];
      lo_next = {base[0], lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply / divide unit (WIDTH cycles per operation plus a sign-fix cycle).
// Define MULDIV_MACC_EN to enable MADD/MSUB accumulation through the ACC state.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned    CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH-1:0] wh, wl;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             is_div, neg_res, neg_rem, b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic             op_div;

`ifdef MULDIV_MACC_EN
  logic               is_macc, is_sub;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_res;
`else
  logic unused_acc;
  assign unused_acc = ^{acc_hi, acc_lo};
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div     (is_div),
    .hi      (wh),
    .lo      (wl),
    .b       (opnd_r),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  always_comb begin
    op_div   = (op_t'(op) == OP_DIV);
    mag_a    = (sign && srca[WIDTH-1]) ? -srca : srca;
    mag_b    = (sign && srcb[WIDTH-1]) ? -srcb : srcb;
    quo_fix  = neg_res ? -wl : wl;
    rem_fix  = neg_rem ? -wh : wh;
    prod_fix = neg_res ? -{wh, wl} : {wh, wl};
  end

`ifdef MULDIV_MACC_EN
  always_comb begin
    acc_res = is_sub ? (acc_r - {wh, wl}) : (acc_r + {wh, wl});
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (in_valid) state_n = CALC;
        CALC: begin
          if (cnt == LAST) begin
`ifdef MULDIV_MACC_EN
            state_n = is_macc ? ACC : DONE;
`else
            state_n = DONE;
`endif
          end
        end
`ifdef MULDIV_MACC_EN
        ACC:  state_n = DONE;
`endif
        DONE: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  // Results land in hi/lo only on the edge entering DONE, so a flush leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      dvd_r    <= '0;
      opnd_r   <= '0;
      wh       <= '0;
      wl       <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      b_zero   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
`ifdef MULDIV_MACC_EN
      is_macc  <= 1'b0;
      is_sub   <= 1'b0;
      acc_r    <= '0;
`endif
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt     <= '0;
            dvd_r   <= srca;
            wh      <= '0;
            is_div  <= op_div;
            neg_res <= sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_rem <= sign & srca[WIDTH-1];
            b_zero  <= (srcb == '0);
            if (op_div) begin
              wl     <= mag_a;
              opnd_r <= mag_b;
            end else begin
              wl     <= mag_b;
              opnd_r <= mag_a;
            end
`ifdef MULDIV_MACC_EN
            is_macc <= is_macc_op(op_t'(op));
            is_sub  <= (op_t'(op) == OP_MSUB);
            acc_r   <= {acc_hi, acc_lo};
`endif
          end
        end
        CALC: begin
          if (cnt != LAST) begin
            wh  <= step_hi;
            wl  <= step_lo;
            cnt <= cnt + CW'(1);
          end else if (is_div) begin
            div_zero <= b_zero;
            if (b_zero) begin
              hi <= dvd_r;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
`ifdef MULDIV_MACC_EN
          end else if (is_macc) begin
            {wh, wl} <= prod_fix;
`endif
          end else begin
            {hi, lo} <= prod_fix;
            div_zero <= 1'b0;
          end
        end
`ifdef MULDIV_MACC_EN
        ACC: begin
          {hi, lo} <= acc_res;
          div_zero <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors, queued expectations,
// independent monitor checking results and latency on every out_valid.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [1:0]  op = 2'd0;
  logic        sign = 1'b0;
  logic [31:0] srca = '0, srcb = '0, acc_hi = '0, acc_lo = '0;
  logic        flush = 1'b0;
  logic        busy, out_valid, div_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

`ifdef MULDIV_MACC_EN
  localparam int LAT_MACC = 34;
`else
  localparam int LAT_MACC = 33;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .sign      (sign),
    .srca      (srca),
    .srcb      (srcb),
    .acc_hi    (acc_hi),
    .acc_lo    (acc_lo),
    .flush     (flush),
    .busy      (busy),
    .out_valid (out_valid),
    .hi        (hi),
    .lo        (lo),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per out_valid pulse.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid got=1 exp=0 (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, mon_e.hi});
        chk("result_lo", {32'd0, lo}, {32'd0, mon_e.lo});
        chk("div_zero", {63'd0, div_zero}, {63'd0, mon_e.dz});
        chk("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  // Called away from an edge; returns #1 after the acceptance edge.
  task automatic drive_req(input logic [1:0] o, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ah, input logic [31:0] al,
                           input logic push, input logic [31:0] eh, input logic [31:0] el,
                           input logic edz, input int lat);
    op = o; sign = s; srca = a; srcb = b; acc_hi = ah; acc_lo = al;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("accept_busy", {63'd0, busy}, 64'd1);
    if (push) exp_q.push_back('{eh, el, edz, cyc + lat});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout got busy=%b exp=0", busy);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic s, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ah, input logic [31:0] al, input logic [31:0] eh,
                     input logic [31:0] el, input logic edz, input int lat);
    drive_req(o, s, a, b, ah, al, 1'b1, eh, el, edz, lat);
    wait_idle();
  endtask

  initial begin
    #2 rst = 1'b0;
    #2;
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_hi_lo", {hi, lo}, 64'd0);
    chk("reset_div_zero", {63'd0, div_zero}, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run(2'd0, 1'b1, 32'hFFFFFFFD, 32'h00000005, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33);
    run(2'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, '0, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);

    // Flush at cycle 10 of a MUL, then an immediate new MUL.
    drive_req(2'd0, 1'b0, 32'd123, 32'd456, '0, '0, 1'b0, '0, '0, 1'b0, 0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_hold_hi_lo", {hi, lo}, 64'hFFFFFFFE_00000001);
    run(2'd0, 1'b0, 32'd6, 32'd7, '0, '0, 32'h0, 32'h0000002A, 1'b0, 33);

    run(2'd1, 1'b0, 32'd100, 32'd7, '0, '0, 32'h00000002, 32'h0000000E, 1'b0, 33);
    run(2'd1, 1'b1, 32'hFFFFFFF9, 32'd2, '0, '0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
    run(2'd1, 1'b1, 32'd7, 32'hFFFFFFFE, '0, '0, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33);
    run(2'd1, 1'b1, 32'hFFFFFFF0, 32'd0, '0, '0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1, 33);
    run(2'd1, 1'b0, 32'h00001234, 32'd0, '0, '0, 32'h00001234, 32'hFFFFFFFF, 1'b1, 33);

    // Reset mid-DIV; next request presented as reset releases.
    drive_req(2'd1, 1'b0, 32'd1000, 32'd3, '0, '0, 1'b0, '0, '0, 1'b0, 0);
    repeat (5) @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("midreset_busy", {63'd0, busy}, 64'd0);
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_hi_lo", {hi, lo}, 64'd0);
    chk("midreset_div_zero", {63'd0, div_zero}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run(2'd1, 1'b1, 32'h80000000, 32'hFFFFFFFF, '0, '0, 32'h00000000, 32'h80000000, 1'b0, 33);

`ifdef MULDIV_MACC_EN
    run(2'd2, 1'b0, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, LAT_MACC);
    run(2'd3, 1'b1, 32'd2, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, LAT_MACC);
`else
    run(2'd2, 1'b0, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, LAT_MACC);
    run(2'd3, 1'b1, 32'd2, 32'd3, 32'h0, 32'h0, 32'h00000000, 32'h00000006, 1'b0, LAT_MACC);
`endif

    // In-flight in_valid with different operands must be ignored.
    drive_req(2'd0, 1'b1, 32'h80000000, 32'h80000000, '0, '0, 1'b1,
              32'h40000000, 32'h00000000, 1'b0, 33);
    repeat (4) @(posedge clk);
    #1;
    op = 2'd1; srca = 32'd1; srcb = 32'd1; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    repeat (40) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
